// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - in-order writeback queue with read forwarding in front of the register bank
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     bank_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic                     fwd_hit_a,
    output logic [DATA_W-1:0]        fwd_data_a,
    output logic                     fwd_hit_b,
    output logic [DATA_W-1:0]        fwd_data_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push;
    logic pop;
    logic not_empty;

    // Full is decided by the occupancy counter alone; a same-cycle pop does not open a slot.
    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    // Writes to $zero complete the handshake but are never stored.
    assign push      = in_valid & in_ready & (in_addr != '0);
    assign pop       = not_empty & bank_ready;

    assign wr_en   = pop;
    assign wr_addr = not_empty ? addr_q[head_q] : '0;
    assign wr_data = not_empty ? data_q[head_q] : '0;
    assign count   = count_q;
    assign busy    = not_empty;

    // Next-state for pointers, occupancy, valid bits and entry storage.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (push) begin
            addr_d[tail_q]  = in_addr;
            data_d[tail_q]  = in_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end

        // When both happen the queue is neither empty nor full, so head != tail.
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards anything pending and wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; contents are qualified by the valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Forwarding lookup: walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (rd_addr_a != '0) && (addr_q[idx] == rd_addr_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = data_q[idx];
            end
            if (valid_q[idx] && (rd_addr_b != '0) && (addr_q[idx] == rd_addr_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb/tb_reg_wb_queue.sv - directed vector bench for reg_wb_queue
module tb_reg_wb_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        bank_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        fwd_hit_a;
    logic [31:0] fwd_data_a;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_b;
    logic [2:0]  count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    reg_wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .bank_ready (bank_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_data_a (fwd_data_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_b (fwd_data_b),
        .count      (count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] id;
        logic        br;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [2:0]  e_cnt;
        logic        e_ir;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_ha;
        logic [31:0] e_da;
        logic        e_hb;
        logic [31:0] e_db;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {20'd0, count, in_ready, wr_en, wr_addr, wr_data,
                fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b};
    endfunction

    initial begin
        vec_t v;
        logic [127:0] e;
        int pushed;
        int written;
        int cyc;

        //           iv ia  id            br ra rb  cnt ir we wa wd            ha da     hb db
        // single write
        vecs.push_back('{1, 5, 32'hDEADBEEF, 1, 0, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});
        vecs.push_back('{0, 0, 0,            1, 5, 0,  1, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0});
        vecs.push_back('{0, 0, 0,            0, 5, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});
        // fill and stall
        vecs.push_back('{1, 1, 1,            0, 0, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});
        vecs.push_back('{1, 2, 2,            0, 0, 0,  1, 1, 0, 1, 1,            0, 0,     0, 0});
        vecs.push_back('{1, 3, 3,            0, 0, 0,  2, 1, 0, 1, 1,            0, 0,     0, 0});
        vecs.push_back('{1, 4, 4,            0, 0, 0,  3, 1, 0, 1, 1,            0, 0,     0, 0});
        vecs.push_back('{1, 9, 9,            0, 3, 4,  4, 0, 0, 1, 1,            1, 3,     1, 4});
        vecs.push_back('{0, 0, 0,            1, 0, 0,  4, 0, 1, 1, 1,            0, 0,     0, 0});
        vecs.push_back('{0, 0, 0,            1, 0, 0,  3, 1, 1, 2, 2,            0, 0,     0, 0});
        vecs.push_back('{0, 0, 0,            1, 0, 0,  2, 1, 1, 3, 3,            0, 0,     0, 0});
        vecs.push_back('{0, 0, 0,            1, 0, 9,  1, 1, 1, 4, 4,            0, 0,     0, 0});
        vecs.push_back('{0, 0, 0,            1, 0, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});
        // forwarding youngest
        vecs.push_back('{1, 7, 32'h11,       0, 0, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});
        vecs.push_back('{1, 7, 32'h22,       0, 7, 3,  1, 1, 0, 7, 32'h11,       1, 32'h11, 0, 0});
        vecs.push_back('{0, 0, 0,            0, 7, 3,  2, 1, 0, 7, 32'h11,       1, 32'h22, 0, 0});
        vecs.push_back('{0, 0, 0,            1, 7, 3,  2, 1, 1, 7, 32'h11,       1, 32'h22, 0, 0});
        vecs.push_back('{0, 0, 0,            1, 7, 7,  1, 1, 1, 7, 32'h22,       1, 32'h22, 1, 32'h22});
        vecs.push_back('{0, 0, 0,            1, 7, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});
        // register 0
        vecs.push_back('{1, 0, 32'hFF,       1, 0, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});
        vecs.push_back('{0, 0, 0,            1, 0, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});
        // simultaneous push and pop
        vecs.push_back('{1, 3, 32'h33,       1, 0, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});
        vecs.push_back('{1, 4, 32'h44,       1, 0, 0,  1, 1, 1, 3, 32'h33,       0, 0,     0, 0});
        vecs.push_back('{0, 0, 0,            1, 4, 0,  1, 1, 1, 4, 32'h44,       1, 32'h44, 0, 0});
        vecs.push_back('{0, 0, 0,            1, 0, 0,  0, 1, 0, 0, 0,            0, 0,     0, 0});

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_data    = '0;
        bank_ready = 1'b0;
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outs", outs(), {20'd0, 3'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0});
        chk("reset_busy", {127'd0, busy}, 128'd0);

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            in_valid   = v.iv;
            in_addr    = v.ia;
            in_data    = v.id;
            bank_ready = v.br;
            rd_addr_a  = v.ra;
            rd_addr_b  = v.rb;
            #1;
            e = {20'd0, v.e_cnt, v.e_ir, v.e_we, v.e_wa, v.e_wd, v.e_ha, v.e_da, v.e_hb, v.e_db};
            chk($sformatf("vec%0d", i), outs(), e);
            chk($sformatf("vec%0d_busy", i), {127'd0, busy}, {127'd0, (v.e_cnt != 0)});
        end

        // streaming across pointer wrap with bank_ready toggling
        pushed  = 0;
        written = 0;
        cyc     = 0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        while ((pushed < 10 || written < 10) && cyc < 200) begin
            @(negedge clk);
            in_valid   = (pushed < 10);
            in_addr    = 5'(pushed + 1);
            in_data    = 32'hC0DE_0000 + 32'(pushed);
            bank_ready = cyc[0];
            #1;
            if (wr_en) begin
                chk($sformatf("stream_wr%0d", written), {91'd0, bank_ready, wr_addr, wr_data},
                    {91'd0, 1'b1, 5'(written + 1), 32'hC0DE_0000 + 32'(written)});
                written++;
            end
            if (in_valid && in_ready) pushed++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_done", {64'd0, 32'(pushed), 32'(written)}, {64'd0, 32'd10, 32'd10});
        @(negedge clk);
        bank_ready = 1'b1;
        #1;
        chk("stream_empty", {125'd0, count}, 128'd0);

        // reset in the middle of operation
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_addr    = 5'(k + 10);
            in_data    = 32'(k + 100);
            bank_ready = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("mid_count3", {125'd0, count}, 128'd3);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_addr  = 5'd6;
        in_data  = 32'h66;
        @(negedge clk);
        rst        = 1'b0;
        in_valid   = 1'b0;
        bank_ready = 1'b1;
        rd_addr_a  = 5'd6;
        rd_addr_b  = 5'd10;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("post_rst%0d", k), {123'd0, count, wr_en, fwd_hit_a, fwd_hit_b},
                {123'd0, 3'd0, 1'b0, 1'b0, 1'b0});
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
